// File: rtl/stage_seq_pkg.sv
// Shared types and constants for the stage sequencer.
package stage_seq_pkg;

  typedef enum logic [1:0] {
    MODE_IDLE = 2'd0,
    MODE_LOAD = 2'd1,
    MODE_RUN  = 2'd2,
    MODE_HALT = 2'd3
  } mode_t;

  localparam logic [7:0] START_BYTE_DEF = 8'hAA;

  localparam int NUM_STAGES_DEF = 5;
  localparam int LAT_W_DEF      = 3;
  localparam int LED_W_DEF      = 8;

  // Stage indices of the 5-stage core.
  localparam int STG_FETCH    = 0;
  localparam int STG_DECODE   = 1;
  localparam int STG_EXECUTE  = 2;
  localparam int STG_MEMORY   = 3;
  localparam int STG_WRITEREG = 4;

endpackage

// File: rtl/stage_sequencer_if.sv
// Bundle of boot, stage-handshake and status signals of the stage sequencer.
// With STAGE_SEQ_PERF_EN defined it also carries the performance counters.
interface stage_sequencer_if
  import stage_seq_pkg::*;
#(
  parameter int NUM_STAGES = NUM_STAGES_DEF,
  parameter int LAT_W      = LAT_W_DEF,
  parameter int LED_W      = LED_W_DEF
);
  localparam int IDX_W = $clog2(NUM_STAGES);

  logic                        rx_valid;
  logic [7:0]                  rx_data;
  logic                        load_done;
  logic [NUM_STAGES*LAT_W-1:0] stage_lat;
  logic [NUM_STAGES-1:0]       stage_ready;
  logic                        halt_req;

  mode_t                       mode;
  logic [IDX_W-1:0]            stage_idx;
  logic [NUM_STAGES-1:0]       stage_oh;
  logic [NUM_STAGES-1:0]       stage_latch;
  logic                        retire;
  logic [LED_W-1:0]            led;
`ifdef STAGE_SEQ_PERF_EN
  logic [31:0]                 retired_cnt;
  logic [31:0]                 stall_cnt;
`endif

  // Environment side: core top / loader / UART.
  modport master (
    output rx_valid, rx_data, load_done, stage_lat, stage_ready, halt_req,
`ifdef STAGE_SEQ_PERF_EN
    input  retired_cnt, stall_cnt,
`endif
    input  mode, stage_idx, stage_oh, stage_latch, retire, led
  );

  // Sequencer side.
  modport slave (
    input  rx_valid, rx_data, load_done, stage_lat, stage_ready, halt_req,
`ifdef STAGE_SEQ_PERF_EN
    output retired_cnt, stall_cnt,
`endif
    output mode, stage_idx, stage_oh, stage_latch, retire, led
  );

endinterface

// File: rtl/stage_timer.sv
// Per-stage latency timer: counts cycles spent in the current stage, compares
// against that stage's minimum latency and gates with its ready to form advance.
// With STAGE_SEQ_PERF_EN defined it also reports stall cycles.
module stage_timer
  import stage_seq_pkg::*;
#(
  parameter int NUM_STAGES = NUM_STAGES_DEF,
  parameter int LAT_W      = LAT_W_DEF,
  parameter int IDX_W      = $clog2(NUM_STAGES)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        run_i,
  input  logic [IDX_W-1:0]            stage_idx_i,
  input  logic [NUM_STAGES*LAT_W-1:0] stage_lat_i,
  input  logic [NUM_STAGES-1:0]       stage_ready_i,
`ifdef STAGE_SEQ_PERF_EN
  output logic                        stall_o,
`endif
  output logic                        advance_o
);

  logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;
  logic [LAT_W-1:0] lat_sel;
  logic             ready_sel;
  logic             lat_met;

  assign lat_sel   = stage_lat_i[int'(stage_idx_i) * LAT_W +: LAT_W];
  assign ready_sel = stage_ready_i[stage_idx_i];
  assign lat_met   = (lat_cnt_q >= lat_sel);

  // A reset cycle never produces an advance, so no strobe escapes during rst.
  assign advance_o = run_i && !rst && lat_met && ready_sel;
`ifdef STAGE_SEQ_PERF_EN
  assign stall_o   = run_i && lat_met && !ready_sel;
`endif

  // Next count: cleared outside RUN and on advance, otherwise saturating increment.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    lat_cnt_d = lat_cnt_q;
    if (!run_i || advance_o) begin
      lat_cnt_d = '0;
    end else if (lat_cnt_q != '1) begin
      lat_cnt_d = lat_cnt_q + 1'b1;
    end
  end

  // Latency counter register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    if (rst) begin
      lat_cnt_q <= '0;
    end else begin
      lat_cnt_q <= lat_cnt_d;
    end
  end

endmodule

// File: rtl/stage_sequencer.sv
// Multi-cycle pipeline sequencer: boot gate (UART start byte, program load),
// then steps through NUM_STAGES stages with per-stage minimum latency and ready
// handshake, emitting latch strobes and a retire pulse; supports halt/reload.
// Optional feature macro: STAGE_SEQ_PERF_EN adds retired_cnt / stall_cnt.
module stage_sequencer
  import stage_seq_pkg::*;
#(
  parameter int         NUM_STAGES = NUM_STAGES_DEF,
  parameter int         LAT_W      = LAT_W_DEF,
  parameter logic [7:0] START_BYTE = START_BYTE_DEF,
  parameter int         LED_W      = LED_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  stage_sequencer_if.slave bus
);

  localparam int               IDX_W    = $clog2(NUM_STAGES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);

  mode_t                 mode_q, mode_d;
  logic [IDX_W-1:0]      stage_idx_q, stage_idx_d;
  logic                  halt_pend_q, halt_pend_d;
  logic [NUM_STAGES-1:0] stage_oh_q, stage_oh_d;
  logic [LED_W-1:0]      led_q, led_d;

  logic run;
  logic start_hit;
  logic last_stage;
  logic advance;
  logic retire;

  assign run        = (mode_q == MODE_RUN);
  assign start_hit  = bus.rx_valid && (bus.rx_data == START_BYTE);
  assign last_stage = (stage_idx_q == LAST_IDX);

`ifdef STAGE_SEQ_PERF_EN
  logic stall;
`endif

  stage_timer #(
    .NUM_STAGES (NUM_STAGES),
    .LAT_W      (LAT_W),
    .IDX_W      (IDX_W)
  ) u_timer (
    .clk           (clk),
    .rst           (rst),
    .run_i         (run),
    .stage_idx_i   (stage_idx_q),
    .stage_lat_i   (bus.stage_lat),
    .stage_ready_i (bus.stage_ready),
`ifdef STAGE_SEQ_PERF_EN
    .stall_o       (stall),
`endif
    .advance_o     (advance)
  );

  // Strobes are combinational so consumers capture on the advancing edge itself.
  assign retire          = advance && last_stage;
  assign bus.stage_latch = advance ? (NUM_STAGES'(1) << stage_idx_q) : '0;
  assign bus.retire      = retire;

  // Mode / stage sequencing; registered outputs derived from the next state.
  always_comb begin
    mode_d      = mode_q;
    stage_idx_d = stage_idx_q;
    halt_pend_d = halt_pend_q;
    unique case (mode_q)
      MODE_IDLE: begin
        // load_done is deliberately not looked at here.
        if (start_hit) mode_d = MODE_LOAD;
      end
      MODE_LOAD: begin
        if (bus.load_done) begin
          mode_d      = MODE_RUN;
          stage_idx_d = '0;
        end
      end
      MODE_RUN: begin
        if (bus.halt_req) halt_pend_d = 1'b1;
        if (advance) begin
          if (last_stage) begin
            stage_idx_d = '0;
            // Halt only takes effect at an instruction boundary.
            if (halt_pend_q || bus.halt_req) begin
              mode_d      = MODE_HALT;
              halt_pend_d = 1'b0;
            end
          end else begin
            stage_idx_d = stage_idx_q + 1'b1;
          end
        end
      end
      MODE_HALT: begin
        if (start_hit) begin
          mode_d      = MODE_LOAD;
          halt_pend_d = 1'b0;
        end
      end
      default: mode_d = MODE_IDLE;
    endcase

    stage_oh_d = (mode_d == MODE_RUN) ? (NUM_STAGES'(1) << stage_idx_d) : '0;
    led_d      = LED_W'({mode_d, stage_idx_d});
  end

  // Sequencer state and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q      <= MODE_IDLE;
      stage_idx_q <= '0;
      halt_pend_q <= 1'b0;
      stage_oh_q  <= '0;
      led_q       <= '0;
    end else begin
      mode_q      <= mode_d;
      stage_idx_q <= stage_idx_d;
      halt_pend_q <= halt_pend_d;
      stage_oh_q  <= stage_oh_d;
      led_q       <= led_d;
    end
  end

  assign bus.mode      = mode_q;
  assign bus.stage_idx = stage_idx_q;
  assign bus.stage_oh  = stage_oh_q;
  assign bus.led       = led_q;

`ifdef STAGE_SEQ_PERF_EN
  logic [31:0] retired_cnt_q, retired_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic        load_entry;

  assign load_entry = (mode_d == MODE_LOAD) && (mode_q != MODE_LOAD);

  // Performance counters: cleared on each program (re)load, wrap at 2^32.
  always_comb begin
    retired_cnt_d = retired_cnt_q;
    stall_cnt_d   = stall_cnt_q;
    if (load_entry) begin
      retired_cnt_d = '0;
      stall_cnt_d   = '0;
    end else begin
      if (retire) retired_cnt_d = retired_cnt_q + 32'd1;
      if (stall)  stall_cnt_d   = stall_cnt_q + 32'd1;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      retired_cnt_q <= '0;
      stall_cnt_q   <= '0;
    end else begin
      retired_cnt_q <= retired_cnt_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign bus.retired_cnt = retired_cnt_q;
  assign bus.stall_cnt   = stall_cnt_q;
`endif

endmodule
